// File: rtl/periph_pkg.sv
// Shared encodings for the peripheral bus master: request op codes and FSM states.
package periph_pkg;

   // Request operation encoding as presented on req_op
   typedef enum logic [1:0] {
      OP_READ_IN  = 2'b00,
      OP_LOAD_OUT = 2'b01,
      OP_LOAD_DIR = 2'b10,
      OP_RESERVED = 2'b11
   } op_e;

   // Master FSM states
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      TURN = 3'd2,
      RD   = 3'd3,
      RESP = 3'd4
   } state_e;

   // True for the two ops that drive the bus toward the peripheral
   function automatic logic is_write(input op_e op);
      return (op == OP_LOAD_OUT) || (op == OP_LOAD_DIR);
   endfunction

endpackage

// File: rtl/bus_driver.sv
// N-bit tristate driver: puts data on the shared bus only while enabled.
module bus_driver #(
   parameter int unsigned N = 64
) (
   input  logic [N-1:0] data,
   input  logic         enable,
   inout  wire  [N-1:0] bus
);

   assign bus = enable ? data : {N{1'bz}};

endmodule

// File: rtl/peripheral_bus_master.sv
// Peripheral bus master: turns CPU requests into single-cycle strobes on a
// shared tristate bus and returns one response per accepted request.
module peripheral_bus_master
   import periph_pkg::*;
#(
   parameter int unsigned N = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [1:0]   req_op,
   input  logic [N-1:0] req_data,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] rsp_data,
   output logic         rsp_err,
   inout  wire  [N-1:0] data_bus,
   output logic         READ_IN,
   output logic         LOAD_OUT,
   output logic         LOAD_DIR
);

   state_e       state_q;
   state_e       state_d;
   op_e          op_q;
   logic [N-1:0] data_q;
   logic [N-1:0] rsp_data_q;
   logic         rsp_err_q;
   logic         drive_en;
   logic         accept;

   assign accept = (state_q == IDLE) && req_valid;

   // State register; reset wins over any handshake on the same edge
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request latch and response registers; response is cleared at acceptance
   // so writes and reserved ops report zero data
   always_ff @(posedge clock) begin
      if (reset) begin
         op_q       <= OP_READ_IN;
         data_q     <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         if (accept) begin
            op_q       <= op_e'(req_op);
            data_q     <= req_data;
            rsp_data_q <= '0;
            rsp_err_q  <= (op_e'(req_op) == OP_RESERVED);
         end
         if (state_q == RD) begin
            rsp_data_q <= data_bus;
         end
      end
   end

   // Next-state and Moore output decode
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      READ_IN   = 1'b0;
      LOAD_OUT  = 1'b0;
      LOAD_DIR  = 1'b0;
      drive_en  = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (op_e'(req_op) == OP_RESERVED) begin
                  state_d = RESP;
               end else if (is_write(op_e'(req_op))) begin
                  state_d = WR;
               end else begin
                  state_d = TURN;
               end
            end
         end
         WR: begin
            drive_en = 1'b1;
            LOAD_OUT = (op_q == OP_LOAD_OUT);
            LOAD_DIR = (op_q == OP_LOAD_DIR);
            state_d  = RESP;
         end
         TURN: begin
            state_d = RD;
         end
         RD: begin
            READ_IN = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rsp_data = rsp_data_q;
   assign rsp_err  = rsp_err_q;

   bus_driver #(
      .N (N)
   ) u_bus_driver (
      .data   (data_q),
      .enable (drive_en),
      .bus    (data_bus)
   );

endmodule

// File: tb/tb_peripheral_bus_master.sv
// Scoreboard bench for peripheral_bus_master: stimulus pushes expected
// responses, a negedge monitor checks protocol every cycle and pops on handshake.
module tb_peripheral_bus_master;

   localparam int unsigned N = 64;

   typedef struct {
      logic [N-1:0] data;      // expected rsp_data
      logic         err;       // expected rsp_err
      int           lat;       // accept edge to rsp_valid, in edges
      logic [1:0]   op;        // decides which strobe must appear
      logic [N-1:0] wr_data;   // expected bus value under the write strobe
   } exp_t;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [1:0]   req_op = 2'b00;
   logic [N-1:0] req_data = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b1;
   logic [N-1:0] rsp_data;
   logic         rsp_err;
   wire  [N-1:0] data_bus;
   logic         READ_IN;
   logic         LOAD_OUT;
   logic         LOAD_DIR;

   logic [N-1:0] periph_val = '0;
   exp_t         sb[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   logic         stim_done = 1'b0;

   // Peripheral model: drives its pin latch onto the bus under READ_IN
   assign data_bus = READ_IN ? periph_val : {N{1'bz}};

   peripheral_bus_master #(
      .N (N)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .data_bus  (data_bus),
      .READ_IN   (READ_IN),
      .LOAD_OUT  (LOAD_OUT),
      .LOAD_DIR  (LOAD_DIR)
   );

   always #5 clock = ~clock;

   // Edge counter used for latency measurement
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: per-cycle protocol checks plus scoreboard compare on responses
   int           acc_cyc = 0;
   int           n_lo = 0, n_ld = 0, n_ri = 0;
   logic [N-1:0] wr_seen = '0;
   logic         first = 1'b1;
   always @(negedge clock) begin
      if (reset) begin
         n_lo = 0; n_ld = 0; n_ri = 0; first = 1'b1;
      end else begin
         chk("one_strobe", N'(32'(READ_IN) + 32'(LOAD_OUT) + 32'(LOAD_DIR) <= 1), N'(1));
         chk("drive_only_on_write", N'(dut.u_bus_driver.enable), N'(LOAD_OUT | LOAD_DIR));
         if (READ_IN) n_ri++;
         if (LOAD_OUT) begin n_lo++; wr_seen = data_bus; end
         if (LOAD_DIR) begin n_ld++; wr_seen = data_bus; end
         if (rsp_valid) begin
            chk("req_ready_low_in_resp", N'(req_ready), N'(0));
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rsp: got rsp_data 0x%016h expected no response", rsp_data);
            end else begin
               if (first) begin
                  chk("latency", N'(cyc - acc_cyc), N'(sb[0].lat));
                  chk("n_load_out", N'(n_lo), N'(sb[0].op == 2'b01));
                  chk("n_load_dir", N'(n_ld), N'(sb[0].op == 2'b10));
                  chk("n_read_in", N'(n_ri), N'(sb[0].op == 2'b00));
                  if (sb[0].op == 2'b01 || sb[0].op == 2'b10)
                     chk("bus_under_strobe", wr_seen, sb[0].wr_data);
                  first = 1'b0;
               end
               chk("rsp_data", rsp_data, sb[0].data);
               chk("rsp_err", N'(rsp_err), N'(sb[0].err));
               if (rsp_ready) begin
                  void'(sb.pop_front());
                  first = 1'b1;
               end
            end
         end
         if (req_valid && req_ready) begin
            acc_cyc = cyc;
            n_lo = 0; n_ld = 0; n_ri = 0;
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL req_ready_timeout: got 0 expected 1");
      end
   endtask

   // Issues one request; pushes its expectation when exp is requested
   task automatic issue(input logic [1:0] op, input logic [N-1:0] d, input logic [N-1:0] rd,
                        input logic push);
      exp_t e;
      wait_ready();
      e.op = op; e.wr_data = d;
      e.err = (op == 2'b11);
      e.data = (op == 2'b00) ? rd : '0;
      e.lat = (op == 2'b00) ? 3 : (op == 2'b11) ? 1 : 2;
      if (push) sb.push_back(e);
      req_valid = 1'b1; req_op = op; req_data = d;
      @(posedge clock); #1;
      // scramble inputs to show the request was latched
      req_valid = 1'b0; req_op = ~op; req_data = ~d;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      chk("sb_drained", N'(sb.size()), N'(0));
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_req_ready"}, N'(req_ready), N'(1));
      chk({tag, "_rsp_valid"}, N'(rsp_valid), N'(0));
      chk({tag, "_strobes"}, N'({READ_IN, LOAD_OUT, LOAD_DIR}), N'(0));
      chk({tag, "_drive"}, N'(dut.u_bus_driver.enable), N'(0));
      chk({tag, "_rsp_err"}, N'(rsp_err), N'(0));
   endtask

   initial begin
      int n;
      // Reset with req_valid held high: reset must win
      req_valid = 1'b1; req_op = 2'b01; req_data = 64'h1111_2222_3333_4444;
      repeat (3) @(posedge clock);
      #1;
      check_idle("reset");
      chk("reset_rsp_data", rsp_data, '0);
      req_valid = 1'b0; reset = 1'b0;
      @(posedge clock); #1;

      // Load-dir with immediate response acceptance
      issue(2'b10, 64'h0000_0000_FFFF_0000, '0, 1'b1);
      drain();

      // Read with peripheral value
      periph_val = 64'hDEAD_BEEF_00C0_FFEE;
      issue(2'b00, 64'h5555_5555_5555_5555, periph_val, 1'b1);
      drain();

      // Load-out followed by read while the CPU stalls the response 4 cycles
      periph_val = 64'h0123_4567_89AB_CDEF;
      rsp_ready = 1'b0;
      fork
         begin
            issue(2'b01, 64'hA5A5_0000_FFFF_5A5A, '0, 1'b1);
            issue(2'b00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b1);
         end
         begin
            n = 0;
            while (!rsp_valid && n < 20) begin @(posedge clock); #1; n++; end
            repeat (4) @(posedge clock);
            #1 rsp_ready = 1'b1;
         end
      join
      drain();

      // Reserved op
      issue(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, '0, 1'b1);
      drain();

      // Back-to-back writes of both kinds
      issue(2'b01, 64'h8000_0000_0000_0001, '0, 1'b1);
      issue(2'b10, 64'h7FFF_FFFF_FFFF_FFFE, '0, 1'b1);
      drain();

      // Reset while in WR: no response may follow
      issue(2'b01, 64'hCAFE_CAFE_CAFE_CAFE, '0, 1'b0);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check_idle("rst_wr");
      repeat (4) @(posedge clock);
      #1 chk("rst_wr_no_rsp", N'(rsp_valid), N'(0));

      // Reset while in RD
      issue(2'b00, 64'h0, '0, 1'b0);
      @(posedge clock); #1;
      chk("rd_state_read_in", N'(READ_IN), N'(1));
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check_idle("rst_rd");
      chk("rst_rd_rsp_data", rsp_data, '0);
      repeat (4) @(posedge clock);
      #1 chk("rst_rd_no_rsp", N'(rsp_valid), N'(0));

      // A normal read after reset recovery
      periph_val = 64'hFEDC_BA98_7654_3210;
      issue(2'b00, 64'h0, periph_val, 1'b1);
      drain();

      stim_done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      if (!stim_done) begin
         $display("FAIL watchdog: got timeout expected completion");
         $fatal(1, "watchdog expired");
      end
   end

endmodule
